conv_seq_ctrl: RTL
==================

# conv_seq_ctrl

Frame sequencer for the 3x3 convolution datapath. It accepts a raster-order pixel stream for one WIDTH x HEIGHT frame and tracks row and column. It drives the datapath line-buffer shift enable and qualifies the datapath output so that only windows lying fully inside the frame are flagged valid. It replaces free-running per-cycle feeding with a start/ready handshake and signals end of frame once the datapath pipeline has drained.

## Interface
- WIDTH, 220, pixels per row (>= K)
- HEIGHT, 220, rows per frame (>= K)
- K, 3, kernel size; a window is complete when row >= K-1 and col >= K-1
- LAT, 1, datapath register stages from shift_en to pxl_out (>= 1)
- CW, $clog2(WIDTH), column index width
- RW, $clog2(HEIGHT), row index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- in_valid  in  1  upstream pixel present on the pixel bus
- in_ready  out  1  controller accepts a pixel this cycle
- shift_en  out  1  line-buffer/window shift enable, equal to in_valid & in_ready
- col_idx  out  CW  column of the pixel accepted next
- row_idx  out  RW  row of the pixel accepted next
- out_valid  out  1  datapath pxl_out holds a valid interior result this cycle
- busy  out  1  state is RUN or DRAIN
- frame_done  out  1  one-cycle pulse coincident with the final out_valid
- out_count  out  16  number of out_valid pulses in the current or last frame

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- IDLE: in_ready = 0. On start, clear col_idx, row_idx and out_count, then go to RUN.
- RUN: in_ready = 1. On each accept (in_valid & in_ready):
  - col_idx increments.
  - At WIDTH-1, col_idx wraps to 0 and row_idx increments.
  - An accept at (HEIGHT-1, WIDTH-1) moves the FSM to DRAIN, and row_idx and col_idx clear to 0.
- DRAIN: in_ready = 0. The state lasts exactly LAT cycles, then returns to IDLE.
- win_valid (internal, combinational) = shift_en & (row_idx >= K-1) & (col_idx >= K-1).
- out_valid is win_valid delayed through a LAT-deep register pipe.
- out_count increments on each out_valid cycle. It saturates at 16'hFFFF and holds its value in IDLE.
- A frame produces (WIDTH-K+1)*(HEIGHT-K+1) out_valid pulses. With defaults this is 218*218 = 47524.
- in_valid low in RUN stalls the controller: counters hold and shift_en = 0. The delay pipe keeps advancing and shifts in 0.
- start in RUN or DRAIN is ignored.
- start and reset asserted together: reset wins.
- frame_done = 1 in the final DRAIN cycle, which is the cycle carrying the last out_valid.

## Timing
- Reset values: state IDLE; in_ready, shift_en, out_valid, busy and frame_done all 0; col_idx, row_idx and out_count all 0; delay pipe cleared.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). No frame_done is issued. A new start is required afterwards.
- start sampled at edge E: in_ready is 1 in the cycle after E.
- A pixel accepted at edge E produces an out_valid (if interior) in the cycle following edge E+LAT-1, i.e. LAT edges later.
- The last accept occurs at edge E. DRAIN then occupies the LAT cycles after E. frame_done and busy are high through the final one, and the FSM is in IDLE after edge E+LAT.
- A start arriving in the same cycle as frame_done is ignored. The earliest accepted start is the first IDLE cycle.
- in_ready, busy and frame_done are registered state decodes. shift_en is combinational from in_valid.

## Test plan
- Reset then idle, 10 cycles with in_valid = 1, no start -> in_ready = 0, shift_en = 0, out_valid = 0, out_count = 0.
- WIDTH=5, HEIGHT=4, LAT=1, start then in_valid held high:
  - out_valid on accepts 13-15 and 18-20 (1-based), each one cycle after its accept.
  - out_count = 6.
  - frame_done coincides with the 6th out_valid, and in_ready drops after accept 20.
- Same frame with in_valid low every third cycle -> same 6 outputs, correct row/col sequence, no out_valid while stalled.
- Defaults, full 48400-pixel frame -> out_count = 47524, frame_done exactly once, busy low afterwards.
- Reset asserted at accept 200 of a default frame -> all outputs 0 at once; a subsequent start gives a clean frame with out_count = 47524.
- LAT=3, WIDTH=5, HEIGHT=4 -> each out_valid 3 cycles after its accept; DRAIN lasts 3 cycles; start during DRAIN ignored.

Source files
------------

// File: rtl/conv_seq_if.sv
// Handshake and status bundle between the convolution frame sequencer
// and the pixel source / datapath consumer.
interface conv_seq_if #(
  parameter int CW = 8,
  parameter int RW = 8
);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          shift_en;
  logic [CW-1:0] col_idx;
  logic [RW-1:0] row_idx;
  logic          out_valid;
  logic          busy;
  logic          frame_done;
  logic [15:0]   out_count;

  modport master (
    output start,
    output in_valid,
    input  in_ready,
    input  shift_en,
    input  col_idx,
    input  row_idx,
    input  out_valid,
    input  busy,
    input  frame_done,
    input  out_count
  );

  modport slave (
    input  start,
    input  in_valid,
    output in_ready,
    output shift_en,
    output col_idx,
    output row_idx,
    output out_valid,
    output busy,
    output frame_done,
    output out_count
  );

endinterface

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath: raster tracking,
// interior-window qualification and end-of-frame drain.
module conv_seq_ctrl #(
  parameter int WIDTH  = 220,
  parameter int HEIGHT = 220,
  parameter int K      = 3,
  parameter int LAT    = 1,
  parameter int CW     = $clog2(WIDTH),
  parameter int RW     = $clog2(HEIGHT)
) (
  input logic       clk,
  input logic       reset,
  conv_seq_if.slave bus
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row;
  logic [RW-1:0] row_nxt;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;
  logic [15:0]   cnt;
  logic [15:0]   cnt_nxt;
  logic [LAT-1:0] pipe;

  logic accept;
  logic win_valid;
  logic col_last;
  logic row_last;
  logic drain_end;
  logic out_v;

  assign accept    = bus.in_valid & (state == RUN);
  assign col_last  = (col == CW'(WIDTH - 1));
  assign row_last  = (row == RW'(HEIGHT - 1));
  assign drain_end = (state == DRAIN) && (dcnt == DW'(LAT - 1));
  assign out_v     = pipe[LAT-1];

  assign win_valid = accept
                   & (row >= RW'(K - 1))
                   & (col >= CW'(K - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      dcnt  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      dcnt  <= dcnt_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    dcnt_nxt  = dcnt;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          col_nxt   = '0;
          row_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (col_last) begin
            col_nxt = '0;
            if (row_last) begin
              row_nxt   = '0;
              dcnt_nxt  = '0;
              state_nxt = DRAIN;
            end else begin
              row_nxt = row + RW'(1);
            end
          end else begin
            col_nxt = col + CW'(1);
          end
        end
      end
      DRAIN: begin
        dcnt_nxt = dcnt + DW'(1);
        if (drain_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // results only arrive in RUN/DRAIN; the count is frozen once idle
    if ((state != IDLE) && out_v && (cnt != 16'hFFFF))
      cnt_nxt = cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= win_valid;
      for (int i = 1; i < LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign bus.in_ready   = (state == RUN);
  assign bus.shift_en   = accept;
  assign bus.col_idx    = col;
  assign bus.row_idx    = row;
  assign bus.out_valid  = out_v;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = drain_end;
  assign bus.out_count  = cnt;

endmodule
